// File: rtl/bios_pkg.sv
// bios_pkg: shared definitions for the boot monitor.
//   - ASCII opcode constants received from the UART
//   - reply code enum (status bytes sent back over the UART)
//   - loader state enum
package bios_pkg;

    // Opcodes, ASCII
    localparam logic [7:0] OP_NOP  = 8'h6E;  // 'n'
    localparam logic [7:0] OP_BOOT = 8'h62;  // 'b'
    localparam logic [7:0] OP_RST  = 8'h72;  // 'r'
    localparam logic [7:0] OP_WR   = 8'h77;  // 'w'
    localparam logic [7:0] OP_LD   = 8'h6C;  // 'l'

    // Reply / status bytes, ASCII
    typedef enum logic [7:0] {
        RSP_NOP  = 8'h4E,  // 'N'
        RSP_BOOT = 8'h42,  // 'B'
        RSP_RST  = 8'h52,  // 'R'
        RSP_WR   = 8'h57,  // 'W'
        RSP_ERR  = 8'h45   // 'E'
    } reply_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM_WR,
        S_MEM_RD,
        S_WAIT_RD,
        S_TX_DATA,
        S_TX_RESP,
        S_CPU_RST,
        S_RUN
    } state_e;

endpackage

// File: rtl/bios_shift_reg.sv
// bios_shift_reg: byte-serial shift register with a byte counter.
// Bytes enter at the top and move down, so a little-endian byte stream
// ends up in natural word order; byte_o is always the lowest byte, so
// shifting also serialises the word LSB first.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clk_en        global enable; nothing changes while 0
//   load_i        parallel load of load_data_i, counter cleared
//   shift_i       shift byte_i in at the top, advance the counter
//   load_data_i   parallel load value
//   byte_i        serial input byte
//   data_o        full register contents
//   byte_o        lowest byte (serial output)
//   last_o        counter is at NBYTES-1 (the next shift completes a word)
module bios_shift_reg #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [8*NBYTES-1:0] load_data_i,
    input  logic [7:0]          byte_i,
    output logic [8*NBYTES-1:0] data_o,
    output logic [7:0]          byte_o,
    output logic                last_o
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign data_o = data_q;
    assign byte_o = data_q[7:0];
    assign last_o = (cnt_q == CW'(NBYTES - 1));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            // written with shifts so NBYTES=1 does not need a reversed slice
            data_d = (data_q >> 8) | (W'(byte_i) << (W - 8));
            cnt_d  = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clk_en) begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bios_loader.sv
// bios_loader: UART boot monitor.
// BOOT mode parses single-byte opcodes with little-endian binary payloads:
// memory word write/read over a request/ready port, CPU reset pulse, echo.
// The boot opcode switches to RUN mode, where the UART byte streams are
// passed straight through to the CPU GPIO stream until rst.
// Ports:
//   clk, rst, clk_en                     clock, sync reset, global enable
//   i_data/i_valid/o_in_ready            UART RX byte stream
//   o_data/o_valid/i_out_ready           UART TX byte stream
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ready   memory request port
//   mem_rvalid/mem_rdata                 memory read return
//   cpu_rst                              CPU reset pulse (RST_CYCLES enabled cycles)
//   run_mode                             1 once in RUN mode
//   gpio_rx_*/gpio_tx_*                  CPU byte streams (RUN mode only)
module bios_loader
    import bios_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_in_ready,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_out_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rst,
    output logic              run_mode,
    output logic [7:0]        gpio_rx_data,
    output logic              gpio_rx_valid,
    input  logic              gpio_rx_ready,
    input  logic [7:0]        gpio_tx_data,
    input  logic              gpio_tx_valid,
    output logic              gpio_tx_ready
);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);

    state_e        state_q, state_d;
    reply_e        resp_q, resp_d;
    logic          is_wr_q, is_wr_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;

    logic       run, rx_rdy, tx_vld, rx_fire, tx_fire, mem_fire;
    logic [7:0] tx_byte, rd_byte;
    logic       addr_last, wdat_last, rd_last;
    logic [DATA_W-1:0] rd_word_unused;

    assign run      = (state_q == S_RUN);
    assign rx_rdy   = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign tx_vld   = (state_q == S_TX_RESP) || (state_q == S_TX_DATA);
    assign tx_byte  = (state_q == S_TX_DATA) ? rd_byte :
                      (state_q == S_TX_RESP) ? 8'(resp_q) : '0;
    assign mem_req  = (state_q == S_MEM_WR) || (state_q == S_MEM_RD);
    assign mem_we   = (state_q == S_MEM_WR);
    assign cpu_rst  = (state_q == S_CPU_RST);

    // Handshakes as seen by the loader in BOOT mode (RUN never enables these)
    assign rx_fire  = clk_en && i_valid && rx_rdy;
    assign tx_fire  = clk_en && tx_vld && i_out_ready;
    assign mem_fire = clk_en && mem_req && mem_ready;

    // RUN mode is a pure combinational bypass of both byte streams
    assign run_mode      = run;
    assign o_in_ready    = run ? gpio_rx_ready : rx_rdy;
    assign o_data        = run ? gpio_tx_data  : tx_byte;
    assign o_valid       = run ? gpio_tx_valid : tx_vld;
    assign gpio_rx_data  = run ? i_data : '0;
    assign gpio_rx_valid = run && i_valid;
    assign gpio_tx_ready = run && i_out_ready;

    bios_shift_reg #(.NBYTES(ADDR_W / 8)) u_addr (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .load_i(1'b0), .shift_i(rx_fire && (state_q == S_ADDR)),
        .load_data_i('0), .byte_i(i_data),
        .data_o(mem_addr), .byte_o(), .last_o(addr_last)
    );

    bios_shift_reg #(.NBYTES(DATA_W / 8)) u_wdata (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .load_i(1'b0), .shift_i(rx_fire && (state_q == S_DATA)),
        .load_data_i('0), .byte_i(i_data),
        .data_o(mem_wdata), .byte_o(), .last_o(wdat_last)
    );

    bios_shift_reg #(.NBYTES(DATA_W / 8)) u_rdata (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .load_i(mem_rvalid && (state_q == S_WAIT_RD)),
        .shift_i(tx_fire && (state_q == S_TX_DATA)),
        .load_data_i(mem_rdata), .byte_i(8'h00),
        .data_o(rd_word_unused), .byte_o(rd_byte), .last_o(rd_last)
    );

    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        is_wr_d   = is_wr_q;
        rst_cnt_d = rst_cnt_q;
        unique case (state_q)
            S_IDLE: if (rx_fire) begin
                state_d = S_TX_RESP;
                unique case (i_data)
                    OP_NOP:  resp_d = RSP_NOP;
                    OP_BOOT: resp_d = RSP_BOOT;
                    OP_RST:  state_d = S_CPU_RST;
                    OP_WR:   begin state_d = S_ADDR; is_wr_d = 1'b1; end
                    OP_LD:   begin state_d = S_ADDR; is_wr_d = 1'b0; end
                    default: resp_d = RSP_ERR;
                endcase
            end
            S_ADDR: if (rx_fire && addr_last) state_d = is_wr_q ? S_DATA : S_MEM_RD;
            S_DATA: if (rx_fire && wdat_last) state_d = S_MEM_WR;
            S_MEM_WR: if (mem_fire) begin
                state_d = S_TX_RESP;
                resp_d  = RSP_WR;
            end
            S_MEM_RD:  if (mem_fire) state_d = S_WAIT_RD;
            S_WAIT_RD: if (clk_en && mem_rvalid) state_d = S_TX_DATA;
            S_TX_DATA: if (tx_fire && rd_last) state_d = S_IDLE;
            // the boot reply is the only one followed by RUN instead of IDLE
            S_TX_RESP: if (tx_fire) state_d = (resp_q == RSP_BOOT) ? S_RUN : S_IDLE;
            S_CPU_RST: if (clk_en) begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = S_TX_RESP;
                    resp_d    = RSP_RST;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            resp_q    <= RSP_NOP;
            is_wr_q   <= 1'b0;
            rst_cnt_q <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            is_wr_q   <= is_wr_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

endmodule
